// File: rtl/banked_mem_ctrl.sv
// banked_mem_ctrl
//   Word-interleaved banked SRAM behind a valid/ready request port.
//   - One request in flight at a time.
//   - Programmable access latency.
//   - Byte-strobed writes.
//   - Wrapping read bursts (critical-word-first line fill).
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_wr            1 = write, 0 = read
//   req_addr          byte address (low bits ignored)
//   req_strb          write byte enables
//   req_wdata         write data
//   req_len           read beats minus 1
//   rsp_valid/ready   response beat handshake
//   rsp_rdata         read data (0 on write responses)
//   rsp_last          final beat of transaction
//   rsp_err           per-beat parity error
//
// Build option
//   MEM_PARITY_EN     stores one even-parity bit per byte and flags mismatches
//                     on read beats. Without it rsp_err is always 0.
module banked_mem_ctrl #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 15,
   parameter int NUM_BANKS = 8,
   parameter int LATENCY   = 3,
   parameter int BURST_MAX = 4,
   localparam int STRB_W   = DATA_W / 8,
   localparam int LEN_W    = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [STRB_W-1:0] req_strb,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [LEN_W-1:0]  req_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_last,
   output logic              rsp_err
);

   localparam int BYTE_W = $clog2(STRB_W);
   localparam int WA_W   = ADDR_W - BYTE_W;
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int ROW_W  = WA_W - BANK_W;
   localparam int ROWS   = 2 ** ROW_W;
   localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [WA_W-1:0] LINE_MASK = WA_W'(BURST_MAX - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state;
   logic               wr_q;
   logic [WA_W-1:0]    word_q;
   logic [STRB_W-1:0]  strb_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [LEN_W-1:0]   len_q;
   logic [CNT_W-1:0]   cnt;
   logic [LEN_W-1:0]   beat;

   logic [WA_W-1:0]    word_next;
   logic [WA_W-1:0]    acc_word;
   logic [BANK_W-1:0]  bank_sel;
   logic [ROW_W-1:0]   row;
   logic               commit;

   logic [NUM_BANKS-1:0][DATA_W-1:0] bank_rdata;
   logic [NUM_BANKS-1:0]             bank_err;
   logic [DATA_W-1:0]                rd_data;
   logic                             rd_err;

   // Byte offset within a word carries no information for a word-wide array.
   logic unused_byte_bits;
   assign unused_byte_bits = ^req_addr[BYTE_W-1:0];

   // Next burst word stays inside the BURST_MAX-aligned line, so a burst that
   // starts near the top of memory wraps within its line rather than past DEPTH-1.
   assign word_next = (word_q & ~LINE_MASK) | ((word_q + WA_W'(1)) & LINE_MASK);

   // In RESP the array is read ahead at the next beat's word so the data is
   // ready to register on the handshake edge.
   assign acc_word = (state == RESP) ? word_next : word_q;
   assign bank_sel = acc_word[BANK_W-1:0];
   assign row      = acc_word[WA_W-1:BANK_W];

   // A write lands exactly on the WAIT->RESP edge. A reset in the same cycle
   // suppresses it, so an uncommitted write is dropped.
   assign commit = (state == WAIT) && (cnt == '0) && wr_q && !rst;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_W-1:0] mem [ROWS];
      logic              we;

      assign we = commit && (bank_sel == BANK_W'(b));

      always_ff @(posedge clk) begin
         if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
               if (strb_q[i]) mem[row][i*8 +: 8] <= wdata_q[i*8 +: 8];
            end
         end
      end

      assign bank_rdata[b] = mem[row];

`ifdef MEM_PARITY_EN
      logic [STRB_W-1:0] par [ROWS];
      logic              err_b;

      always_ff @(posedge clk) begin
         if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
               if (strb_q[i]) par[row][i] <= ^wdata_q[i*8 +: 8];
            end
         end
      end

      always_comb begin
         err_b = 1'b0;
         for (int i = 0; i < STRB_W; i++) begin
            err_b = err_b | ((^mem[row][i*8 +: 8]) ^ par[row][i]);
         end
      end

      assign bank_err[b] = err_b;
`else
      assign bank_err[b] = 1'b0;
`endif
   end

   assign rd_data = bank_rdata[bank_sel];
   assign rd_err  = bank_err[bank_sel];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         cnt       <= '0;
         beat      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state     <= WAIT;
                  req_ready <= 1'b0;
                  wr_q      <= req_wr;
                  word_q    <= req_addr[ADDR_W-1:BYTE_W];
                  strb_q    <= req_strb;
                  wdata_q   <= req_wdata;
                  len_q     <= req_wr ? '0 : req_len;
                  cnt       <= CNT_W'(LATENCY - 1);
               end
            end

            WAIT: begin
               if (cnt == '0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  beat      <= '0;
                  if (wr_q) begin
                     rsp_rdata <= '0;
                     rsp_last  <= 1'b1;
                     rsp_err   <= 1'b0;
                  end else begin
                     rsp_rdata <= rd_data;
                     rsp_last  <= (len_q == '0);
                     rsp_err   <= rd_err;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  if (rsp_last) begin
                     state     <= IDLE;
                     req_ready <= 1'b1;
                     rsp_valid <= 1'b0;
                     rsp_last  <= 1'b0;
                     rsp_rdata <= '0;
                     rsp_err   <= 1'b0;
                  end else begin
                     word_q    <= word_next;
                     beat      <= beat + LEN_W'(1);
                     rsp_rdata <= rd_data;
                     rsp_last  <= ((beat + LEN_W'(1)) == len_q);
                     rsp_err   <= rd_err;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Bench for banked_mem_ctrl.
//   A table of transactions with expected read beats drives the port; expected
//   beats are queued at issue and compared as the DUT presents them. Hand-written
//   sequences cover latency, back-pressure, reset interaction and parity.
module tb_banked_mem_ctrl;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 15;
   localparam int NUM_BANKS = 8;
   localparam int LATENCY   = 3;
   localparam int BURST_MAX = 4;
   localparam int STRB_W    = 4;
   localparam int LEN_W     = 2;

   localparam logic [31:0] WA = 32'hA0A0A0A0;
   localparam logic [31:0] WB = 32'hB1B1B1B1;
   localparam logic [31:0] WC = 32'hC2C2C2C2;
   localparam logic [31:0] WD = 32'hD3D3D3D3;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [STRB_W-1:0] req_strb;
   logic [DATA_W-1:0] req_wdata;
   logic [LEN_W-1:0]  req_len;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_last;
   logic              rsp_err;

   always #5 clk = ~clk;

   banked_mem_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS),
      .LATENCY(LATENCY), .BURST_MAX(BURST_MAX)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_strb(req_strb), .req_wdata(req_wdata),
      .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_last(rsp_last), .rsp_err(rsp_err)
   );

   typedef struct {
      logic                   wr;
      logic [ADDR_W-1:0]      addr;
      logic [STRB_W-1:0]      strb;
      logic [DATA_W-1:0]      wdata;
      logic [LEN_W-1:0]       len;
      logic [3:0][DATA_W-1:0] exp;
      logic [3:0]             err;
   } vec_t;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
      logic              err;
   } beat_t;

   beat_t exp_q[$];
   vec_t  tbl[$];
   beat_t mon_e;
   int    checks = 0;
   int    fails  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [ADDR_W-1:0] a,
                               input logic [STRB_W-1:0] s, input logic [DATA_W-1:0] d,
                               input logic [LEN_W-1:0] l,
                               input logic [DATA_W-1:0] e0 = '0, input logic [DATA_W-1:0] e1 = '0,
                               input logic [DATA_W-1:0] e2 = '0, input logic [DATA_W-1:0] e3 = '0);
      vec_t r;
      r.wr = wr; r.addr = a; r.strb = s; r.wdata = d; r.len = l;
      r.exp = {e3, e2, e1, e0};
      r.err = 4'b0000;
      return r;
   endfunction

   // Scoreboard: every accepted beat is compared against the head of the queue.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_beat actual=%0h required=none", rsp_rdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_beat{data,last,err}", {rsp_rdata, rsp_last, rsp_err},
                {mon_e.data, mon_e.last, mon_e.err});
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         checks++;
         fails++;
         $display("FAIL req_ready_timeout actual=0 required=1");
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!rsp_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!rsp_valid) begin
         checks++;
         fails++;
         $display("FAIL rsp_valid_timeout actual=0 required=1");
      end
   endtask

   // Issues one request; returns #1 after the accept edge.
   task automatic do_txn(input vec_t t);
      wait_ready();
      if (t.wr) begin
         exp_q.push_back('{'0, 1'b1, 1'b0});
      end else begin
         for (int k = 0; k <= int'(t.len); k++)
            exp_q.push_back('{t.exp[k], (k == int'(t.len)), t.err[k]});
      end
      req_valid = 1'b1;
      req_wr    = t.wr;
      req_addr  = t.addr;
      req_strb  = t.strb;
      req_wdata = t.wdata;
      req_len   = t.len;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t t;
      int   n;

      rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
      req_strb = '0; req_wdata = '0; req_len = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset{ready,valid,last,data,err}",
          {req_ready, rsp_valid, rsp_last, rsp_rdata, rsp_err}, {1'b1, 1'b0, 1'b0, 32'h0, 1'b0});
      rst = 1'b0;
      @(posedge clk); #1;

      // Transaction table: writes, full/partial/empty strobes, wrapping bursts.
      tbl.push_back(mk(1, 15'h0010, 4'hF, 32'hDEADBEEF, 0));
      tbl.push_back(mk(0, 15'h0010, 4'h0, 32'h0, 0, 32'hDEADBEEF));
      tbl.push_back(mk(1, 15'h0010, 4'h1, 32'h00000011, 0));
      tbl.push_back(mk(0, 15'h0010, 4'h0, 32'h0, 0, 32'hDEADBE11));
      tbl.push_back(mk(1, 15'h0010, 4'h0, 32'hFFFFFFFF, 0));
      tbl.push_back(mk(0, 15'h0010, 4'h0, 32'h0, 0, 32'hDEADBE11));
      tbl.push_back(mk(1, 15'h0020, 4'hF, WA, 0));
      tbl.push_back(mk(1, 15'h0024, 4'hF, WB, 0));
      tbl.push_back(mk(1, 15'h0028, 4'hF, WC, 0));
      tbl.push_back(mk(1, 15'h002C, 4'hF, WD, 0));
      tbl.push_back(mk(0, 15'h0028, 4'h0, 32'h0, 3, WC, WD, WA, WB));
      tbl.push_back(mk(0, 15'h0020, 4'h0, 32'h0, 1, WA, WB));
      tbl.push_back(mk(0, 15'h002C, 4'h0, 32'h0, 2, WD, WA, WB));
      tbl.push_back(mk(1, 15'h0012, 4'hC, 32'h12340000, 0));
      tbl.push_back(mk(0, 15'h0013, 4'h0, 32'h0, 0, 32'h1234BE11));
      tbl.push_back(mk(1, 15'h7FF0, 4'hF, 32'h44444444, 0));
      tbl.push_back(mk(1, 15'h7FF4, 4'hF, 32'h55555555, 0));
      tbl.push_back(mk(1, 15'h7FF8, 4'hF, 32'h66666666, 0));
      tbl.push_back(mk(1, 15'h7FFC, 4'hF, 32'h77777777, 0));
      tbl.push_back(mk(0, 15'h7FF8, 4'h0, 32'h0, 3,
                       32'h66666666, 32'h77777777, 32'h44444444, 32'h55555555));
      foreach (tbl[i]) do_txn(tbl[i]);
      wait_ready();

      // First beat latency; req_ready low while busy.
      do_txn(mk(0, 15'h0010, 4'h0, 32'h0, 0, 32'h1234BE11));
      chk("req_ready_in_wait", req_ready, 0);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("first_rsp_latency", n, LATENCY);
      wait_ready();

      // Back-pressure on beat 2 of a wrapped burst: D must hold.
      rsp_ready = 1'b0;
      do_txn(mk(0, 15'h0028, 4'h0, 32'h0, 3, WC, WD, WA, WB));
      wait_valid();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("bp_hold_1{valid,data,last}", {rsp_valid, rsp_rdata, rsp_last}, {1'b1, WD, 1'b0});
      @(posedge clk); #1;
      chk("bp_hold_2{valid,data,last}", {rsp_valid, rsp_rdata, rsp_last}, {1'b1, WD, 1'b0});
      rsp_ready = 1'b1;
      wait_ready();

      // Reset during WAIT of a write: write is dropped.
      do_txn(mk(1, 15'h0010, 4'hF, 32'h99999999, 0));
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_wait{valid,ready}", {rsp_valid, req_ready}, {1'b0, 1'b1});
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      do_txn(mk(0, 15'h0010, 4'h0, 32'h0, 0, 32'h1234BE11));
      wait_ready();

      // Reset mid-read for 2 cycles: beats discarded, array intact.
      rsp_ready = 1'b0;
      do_txn(mk(0, 15'h0020, 4'h0, 32'h0, 3, WA, WB, WC, WD));
      wait_valid();
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_resp{valid,ready}", {rsp_valid, req_ready}, {1'b0, 1'b1});
      @(posedge clk); #1;
      chk("rst_held{valid,ready}", {rsp_valid, req_ready}, {1'b0, 1'b1});
      rst = 1'b0;
      exp_q.delete();
      rsp_ready = 1'b1;
      do_txn(mk(0, 15'h0020, 4'h0, 32'h0, 3, WA, WB, WC, WD));
      wait_ready();

      // Reset and request in the same cycle: request is not accepted.
      rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 15'h0010;
      req_wdata = 32'h55555555; req_strb = 4'hF;
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 1'b0;
      n = 0;
      repeat (LATENCY + 2) begin
         @(posedge clk); #1;
         if (rsp_valid || !req_ready) n++;
      end
      chk("rst_beats_req_busy_cycles", n, 0);
      do_txn(mk(0, 15'h0010, 4'h0, 32'h0, 0, 32'h1234BE11));
      wait_ready();

      // Parity: word 0x40 is bank 0, row 2.
      do_txn(mk(1, 15'h0040, 4'hF, 32'h0F0F0F0F, 0));
      do_txn(mk(1, 15'h0044, 4'hF, 32'h12345678, 0));
      wait_ready();
`ifdef MEM_PARITY_EN
      dut.g_bank[0].mem[2][9] = ~dut.g_bank[0].mem[2][9];
      t = mk(0, 15'h0040, 4'h0, 32'h0, 1, 32'h0F0F0D0F, 32'h12345678);
      t.err = 4'b0001;
`else
      t = mk(0, 15'h0040, 4'h0, 32'h0, 1, 32'h0F0F0F0F, 32'h12345678);
`endif
      do_txn(t);
      wait_ready();

      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
